layer2_mac: RTL
===============

# layer2_mac

Second-layer dot-product engine. It takes the ten 16-bit hidden activations produced by the layer-1/sigmoid path and multiplies each by the matching weight read from the layer-2 weight SRAM. It accumulates the ten products at full precision and writes one saturated Q8.8 result into the answer SRAM at a caller-supplied (row, col). It sits directly downstream of the sigmoid stage and upstream of the answer SRAM.

## Interface
- No parameters. Vector length 10 and the Q8.8 format are fixed.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- hid_in  in  160  ten signed Q8.8 activations; element k = hid_in[16k+15:16k]; latched on accepted start
- row_in  in  4  answer-SRAM row; latched on accepted start
- col_in  in  4  answer-SRAM column; latched on accepted start
- w2_addr  out  4  weight-SRAM address (registered)
- q_w2  in  16  weight-SRAM read data; signed Q8.8; valid the cycle after the address is presented
- we  out  1  answer-SRAM write enable, one-cycle pulse
- row  out  4  answer-SRAM row (registered)
- col  out  4  answer-SRAM column (registered)
- wdata  out  16  saturated Q8.8 result
- busy  out  1  high from the cycle after accepted start through the WRITE cycle
- done  out  1  one-cycle pulse, coincident with we

## Operation
- States: IDLE -> FETCH -> DRAIN -> WRITE -> IDLE.
- IDLE:
  - If start=1, latch hid_in, row_in and col_in.
  - Clear the accumulator and address counter k.
  - Go to FETCH.
- FETCH:
  - Lasts 10 cycles. Drive w2_addr=k for k=0..9.
  - From the second FETCH cycle on, accumulate hid[k-1]*q_w2.
  - After k=9, go to DRAIN.
- DRAIN:
  - One cycle. Accumulate hid[9]*q_w2.
  - Go to WRITE.
- WRITE:
  - One cycle. we=1, done=1, wdata=sat(acc>>>8), row/col = latched values.
  - Go to IDLE.
- Arithmetic:
  - Each product is signed 16x16 -> 32-bit (Q16.16).
  - The accumulator is a 36-bit signed value and cannot overflow over 10 terms.
  - Result = acc arithmetic-shifted right by 8. This truncates toward minus infinity; there is no rounding.
  - Saturate to [0x8000, 0x7FFF].
- start outside IDLE, including the WRITE cycle, is ignored and has no side effects.
- hid_in, row_in and col_in changing after acceptance has no effect on the result in progress.
- Asynchronous reset at any time:
  - Return to IDLE immediately.
  - Clear the accumulator and latched operands.
  - Abort any pending write; we must not assert for the aborted job.

## Timing
- Reset values: w2_addr=0, we=0, row=0, col=0, wdata=0, busy=0, done=0.
- Take start sampled high at edge E0 as cycle 0.
- Cycles 1..10: w2_addr = 0..9, busy=1.
- Cycles 2..11: q_w2 for address (cycle-2) is consumed.
- Cycle 12: we=1, done=1, busy=1, wdata/row/col valid.
- Cycle 13: IDLE, busy=0, we=0. A start in cycle 13 is accepted, so back-to-back jobs have a 13-cycle period.
- Start-to-write latency is exactly 12 cycles.
- w2_addr holds its last value (9) outside FETCH until the next job or reset.
- wdata, row and col hold their last written values after WRITE.

## Test plan
- Nominal sum: all hid=0x0100, all weights=0x0100, row=3, col=5, start -> cycle 12: we=1, done=1, row=3, col=5, wdata=0x0A00; w2_addr steps 0..9 in cycles 1..10.
- Signed sum: hid all 0x0100, weights all 0xFF00 -> wdata=0xF600.
- Truncation, positive: hid[0]=0x0001, w[0]=0x0080, all others 0 -> wdata=0x0000.
- Truncation, negative: same as above but w[0]=0xFF80 -> wdata=0xFFFF.
- Saturation, positive: hid all 0x7FFF, weights all 0x7FFF -> wdata=0x7FFF.
- Saturation, negative: hid all 0x7FFF, weights all 0x8000 -> wdata=0x8000.
- Busy/restart:
  - Pulse start again in cycles 4 and 12 -> ignored, exactly one we pulse.
  - Start in cycle 13 -> second write at cycle 25.
- Reset mid-job: assert reset in cycle 6 for one cycle -> all outputs 0 immediately, no we pulse. A new start afterwards gives the correct nominal result 12 cycles later.

Source files
------------

// File: rtl/layer2_mac.sv
// Layer-2 dot product: ten Q8.8 activations x ten SRAM weights, full-precision sum, saturated Q8.8 write.
// Start-to-write latency 12 cycles; start is ignored while busy (13-cycle back-to-back period).
module layer2_mac (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [159:0] hid_in,
  input  logic [3:0]   row_in,
  input  logic [3:0]   col_in,
  output logic [3:0]   w2_addr,
  input  logic [15:0]  q_w2,
  output logic         we,
  output logic [3:0]   row,
  output logic [3:0]   col,
  output logic [15:0]  wdata,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  logic [1:0]          state;
  logic [159:0]        hid;
  logic [3:0]          row_l;
  logic [3:0]          col_l;
  logic signed [35:0]  acc;

  logic [3:0]          mul_idx;
  logic signed [15:0]  hid_sel;
  logic signed [31:0]  prod;
  logic signed [35:0]  acc_next;
  logic signed [35:0]  acc_shift;
  logic [15:0]         sat_val;

  // Weight data lags the address by one cycle, so the activation index trails w2_addr by one.
  always_comb begin
    mul_idx = (state == DRAIN) ? 4'd9 : (w2_addr - 4'd1);
    hid_sel = '0;
    if (mul_idx <= 4'd9) begin
      hid_sel = hid[{mul_idx, 4'b0000} +: 16];
    end
    prod      = 32'(hid_sel) * 32'($signed(q_w2));
    acc_next  = acc + 36'(prod);
    acc_shift = acc_next >>> 8;
    if (acc_shift > 36'sd32767) begin
      sat_val = 16'h7FFF;
    end else if (acc_shift < -36'sd32768) begin
      sat_val = 16'h8000;
    end else begin
      sat_val = acc_shift[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      hid     <= '0;
      row_l   <= '0;
      col_l   <= '0;
      acc     <= '0;
      w2_addr <= '0;
      we      <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      row     <= '0;
      col     <= '0;
      wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            hid     <= hid_in;
            row_l   <= row_in;
            col_l   <= col_in;
            acc     <= '0;
            w2_addr <= '0;
            busy    <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          if (w2_addr != 4'd0) begin
            acc <= acc_next;
          end
          if (w2_addr == 4'd9) begin
            state <= DRAIN;
          end else begin
            w2_addr <= w2_addr + 4'd1;
          end
        end
        DRAIN: begin
          // Final term is folded in combinationally so the result registers alongside we.
          acc   <= acc_next;
          wdata <= sat_val;
          row   <= row_l;
          col   <= col_l;
          we    <= 1'b1;
          done  <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          we    <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
